// File: rtl/filter_sequencer_pkg.sv
// Shared definitions for the filter sequencer: state encoding and default widths.
package filter_sequencer_pkg;

  localparam int DATA_SIZE_DEF = 24;
  localparam int CNT_W         = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TRIG = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } seq_state_t;

endpackage

// File: rtl/filter_sequencer_fifo.sv
// Input sample buffer for the filter sequencer; show-ahead head, power-of-two depth.
module seq_fifo
  import filter_sequencer_pkg::*;
#(
  parameter int DATA_SIZE  = DATA_SIZE_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [DATA_SIZE-1:0]         din,
  output logic [DATA_SIZE-1:0]         dout,
  output logic [$clog2(FIFO_DEPTH):0]  level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  logic [DATA_SIZE-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [LVL_W-1:0]     r_level;
  logic                 w_push;
  logic                 w_pop;

  // Guard both ends locally so a misbehaving caller cannot corrupt the occupancy.
  assign w_push = push && (r_level != FULL_LVL);
  assign w_pop  = pop && (r_level != '0);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign level = r_level;

endmodule

// File: rtl/filter_sequencer.sv
// Feeds buffered samples one at a time to an external filter and presents each result.
// state | meaning
// IDLE  | wait for a buffered sample; load and pop it
// TRIG  | one-cycle filt_sample strobe
// WAIT  | count cycles until filt_done or timeout
// HOLD  | present result until out_ready
module filter_sequencer
  import filter_sequencer_pkg::*;
#(
  parameter int DATA_SIZE  = DATA_SIZE_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_SIZE-1:0]         in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [DATA_SIZE-1:0]         filt_data,
  output logic                         filt_sample,
  input  logic [DATA_SIZE-1:0]         filt_result,
  input  logic                         filt_done,
  output logic [DATA_SIZE-1:0]         out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         timeout_err,
  output logic [$clog2(FIFO_DEPTH):0]  level
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  seq_state_t           r_state;
  seq_state_t           w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [DATA_SIZE-1:0] r_filt_data;
  logic [DATA_SIZE-1:0] r_out_data;
  logic                 r_out_valid;
  logic                 r_timeout_err;
  logic [DATA_SIZE-1:0] w_head;
  logic [LVL_W-1:0]     w_level;
  logic                 w_push;
  logic                 w_load;
  logic                 w_capture;
  logic                 w_timeout;
  logic                 w_release;

  assign in_ready = (w_level != FULL_LVL);
  assign w_push   = in_valid && in_ready;

  seq_fifo #(
    .DATA_SIZE  (DATA_SIZE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_load),
    .din   (in_data),
    .dout  (w_head),
    .level (w_level)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_level != '0) begin
          w_load      = 1'b1;
          w_state_nxt = ST_TRIG;
        end
      end
      ST_TRIG: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        // A done arriving on the last allowed cycle still wins over the timeout.
        if (filt_done) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_HOLD;
        end else if (r_cnt == CNT_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (r_out_valid && out_ready) begin
          w_release   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt         <= '0;
      r_filt_data   <= '0;
      r_out_data    <= '0;
      r_out_valid   <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state == ST_TRIG)      r_cnt <= '0;
      else if (r_state == ST_WAIT) r_cnt <= r_cnt + 1'b1;
      if (w_load) r_filt_data <= w_head;
      if (w_capture) begin
        r_out_data  <= filt_result;
        r_out_valid <= 1'b1;
      end else if (w_release) begin
        r_out_valid <= 1'b0;
      end
      if (w_timeout) r_timeout_err <= 1'b1;
    end
  end

  assign filt_sample = (r_state == ST_TRIG);
  assign filt_data   = r_filt_data;
  assign out_data    = r_out_data;
  assign out_valid   = r_out_valid;
  assign timeout_err = r_timeout_err;
  assign level       = w_level;

endmodule

// File: doc/filter_sequencer.md
FILTER_SEQUENCER -- requirements
Module: filter_sequencer

Interface
REQ-001 The module SHALL have parameter DATA_SIZE, default 24: sample width of the stream and of the filter data ports.
REQ-002 The module SHALL have parameter FIFO_DEPTH, default 4: input buffer depth, a power of two and at least 2.
REQ-003 The module SHALL have parameter TIMEOUT, default 255: maximum cycles to wait for filt_done, in the range 1..255.
REQ-004 The module SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The module SHALL have port in_data, input, DATA_SIZE bits: incoming sample.
REQ-007 The module SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-008 The module SHALL have port in_ready, output, 1 bit: buffer accepts a sample; equals (level != FIFO_DEPTH).
REQ-009 The module SHALL have port filt_data, output, DATA_SIZE bits: sample driven to the filter's data_in.
REQ-010 The module SHALL have port filt_sample, output, 1 bit: one-cycle strobe driven to the filter's sample_trig.
REQ-011 The module SHALL have port filt_result, input, DATA_SIZE bits: the filter's data_out.
REQ-012 The module SHALL have port filt_done, input, 1 bit: the filter's filter_done.
REQ-013 The module SHALL have port out_data, output, DATA_SIZE bits: filtered sample.
REQ-014 The module SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-015 The module SHALL have port out_ready, input, 1 bit: downstream accepts out_data.
REQ-016 The module SHALL have port timeout_err, output, 1 bit: sticky flag, set on any filter timeout.
REQ-017 The module SHALL have port level, output, clog2(FIFO_DEPTH)+1 bits: current buffer occupancy.

Function
REQ-018 Push SHALL occur iff in_valid and in_ready on a clock edge; a push while full SHALL be impossible because in_ready is low.
REQ-019 FSM states SHALL be IDLE, TRIG, WAIT and HOLD.
REQ-020 IDLE: when level>0, the FSM SHALL load the FIFO head into the filt_data register, pop the head, and go to TRIG on the same edge.
REQ-021 TRIG: filt_sample SHALL be 1 for exactly this one cycle; the FSM SHALL then go to WAIT and clear the wait counter to 0.
REQ-022 WAIT: the counter SHALL increment each cycle; on filt_done=1 the module SHALL capture filt_result into out_data, set out_valid=1 and go to HOLD.
REQ-023 WAIT: if the counter reaches TIMEOUT without filt_done, the module SHALL set timeout_err=1, discard the sample and return to IDLE.
REQ-024 When filt_done and the timeout occur in the same cycle, filt_done SHALL take priority.
REQ-025 HOLD: out_data and out_valid SHALL stay stable until out_valid and out_ready are both high; the FSM SHALL then clear out_valid and go to IDLE.
REQ-026 filt_data SHALL be held stable from TRIG until the next load.
REQ-027 filt_done SHALL be ignored in IDLE, TRIG and HOLD.
REQ-028 Latency from first push into an empty FIFO to filt_sample SHALL be 2 cycles: push edge, then pop edge, then TRIG.
REQ-029 A simultaneous push and pop SHALL leave level unchanged and preserve data order.
REQ-030 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-031 timeout_err SHALL be cleared only by reset.

Reset
REQ-032 While reset=0: the FSM SHALL be in IDLE, FIFO pointers and level SHALL be 0, and filt_sample, out_valid and timeout_err SHALL be 0.
REQ-033 While reset=0: filt_data and out_data SHALL be 0, and in_ready SHALL be 1 once level=0.
REQ-034 Reset asserted mid-operation (TRIG, WAIT or HOLD) SHALL abandon the transaction, drop all buffered samples, and produce no filt_sample or out_valid afterwards.
REQ-035 Reset release SHALL be synchronous to clk by the integrating system; the module SHALL NOT add a reset synchronizer.

Structure
REQ-036 A shared package SHALL hold the FSM state encoding (IDLE=0, TRIG=1, WAIT=2, HOLD=3) and the default DATA_SIZE.
REQ-037 The FIFO SHALL be one sub-module, seq_fifo (parameters DATA_SIZE and FIFO_DEPTH; ports push, pop, din, dout, level), using the same clk and reset.
REQ-038 The FSM, wait counter and output registers SHALL be in filter_sequencer.

Verification
REQ-039 Single sample: push 24'h000100 into empty FIFO, filter model asserts filt_done 5 cycles after filt_sample with result 24'h000080 -> filt_sample exactly 1 cycle, 2 cycles after push; out_data=24'h000080 and out_valid=1.
REQ-040 Burst: push 6 samples with out_ready=1 and filter latency 10 -> in_ready=0 when level=4; outputs emerge in push order; no sample lost.
REQ-041 Backpressure: out_ready=0 for 20 cycles in HOLD -> out_data and out_valid stable; no new filt_sample until the handshake.
REQ-042 Timeout: filter never asserts filt_done, TIMEOUT=8 -> timeout_err=1 after 8 WAIT cycles; the next queued sample is triggered; timeout_err stays 1.
REQ-043 Reset in WAIT with 3 samples queued -> level=0, out_valid=0, timeout_err=0, and no filt_sample after release until new pushes.
REQ-044 Stray filt_done in IDLE, and filt_done coincident with the timeout -> the stray pulse is ignored; in the coincident case a result is delivered and timeout_err stays 0.
